rx_hash_steer: RTL and testbench

Parametrised receive-side flow steering block. It passively observes an AXI-Stream Ethernet receive stream and parses the IPv4/TCP/UDP header of each frame. It computes a 32-bit Toeplitz (RSS) hash over the flow tuple with a byte-serial engine, then maps the hash through a writable indirection table to a queue number. Results are emitted once per frame on a valid/ready sideband to the queue dispatcher.

---
 rtl/rx_hash_steer.sv | 205 ++++++++++++++++++++
 tb/tb_rx_hash_steer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_hash_steer.sv
// Passive AXI-Stream receive parser: extracts the IPv4/TCP/UDP flow tuple, runs a
// byte-serial Toeplitz (RSS) hash and maps it through an indirection table to a queue.
module rx_hash_steer #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int INDIR_BITS = 7,
  parameter int QUEUE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [319:0]          hash_key,
  input  logic                  tbl_wr_en,
  input  logic [INDIR_BITS-1:0] tbl_wr_addr,
  input  logic [QUEUE_BITS-1:0] tbl_wr_data,
  output logic [31:0]           m_axis_hash,
  output logic [3:0]            m_axis_hash_type,
  output logic [QUEUE_BITS-1:0] m_axis_hash_queue,
  output logic [31:0]           m_axis_dest_ip,
  output logic [15:0]           m_axis_dest_port,
  output logic                  m_axis_hash_valid,
  input  logic                  m_axis_hash_ready,
  output logic [15:0]           drop_count
);
  localparam int BYTES     = DATA_WIDTH/8;
  localparam int HDR_LEN   = 38;
  localparam int H         = (HDR_LEN + BYTES - 1) / BYTES;
  localparam int BEAT_W    = $clog2(H + 1);
  localparam int TBL_DEPTH = 1 << INDIR_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_HASH, ST_LOAD, ST_OUT} state_e;

  logic [BEAT_W-1:0] beat_q;
  logic              done_q;
  logic [7:0]        hdr_q   [HDR_LEN];
  logic [7:0]        hdr_cur [HDR_LEN];
  logic              hdr_done, short_frame;
  logic [15:0]       frame_len;

  function automatic logic [15:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + 16'(k[i]);
    return c;
  endfunction

  function automatic logic [31:0] hash_byte(input logic [31:0] acc, input logic [7:0] b,
                                            input logic [319:0] key);
    logic [31:0] r;
    r = acc;
    for (int i = 0; i < 8; i++) if (b[7-i]) r = r ^ key[319-i -: 32];
    return r;
  endfunction

  // NOTE: combinational blocks use blocking '=' and assign every output before any
  // conditional update, so no latch is inferred and reads see the updated value.
  always_comb begin
    for (int g = 0; g < HDR_LEN; g++) begin
      hdr_cur[g] = hdr_q[g];
      if (s_axis_tvalid && beat_q == BEAT_W'(g / BYTES))
        hdr_cur[g] = s_axis_tdata[(g % BYTES)*8 +: 8];
    end
  end

  assign frame_len   = 16'(beat_q) * 16'(BYTES) + popcount(s_axis_tkeep);
  assign short_frame = s_axis_tlast && (frame_len < 16'(HDR_LEN));
  assign hdr_done    = s_axis_tvalid && !done_q && (s_axis_tlast || beat_q == BEAT_W'(H-1));

  // NOTE: sequential state is written only with non-blocking '<=' so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      done_q <= 1'b0;
      for (int g = 0; g < HDR_LEN; g++) hdr_q[g] <= '0;
    end else if (s_axis_tvalid) begin
      hdr_q <= hdr_cur;
      if (s_axis_tlast) begin
        beat_q <= '0;
        done_q <= 1'b0;
      end else begin
        if (beat_q != BEAT_W'(H)) beat_q <= beat_q + 1'b1;
        if (hdr_done) done_q <= 1'b1;
      end
    end
  end

  logic        ipv4, frag;
  logic [7:0]  proto;
  logic [3:0]  hd_type, hd_len;
  logic [95:0] hd_tuple;
  logic [31:0] hd_dip;
  logic [15:0] hd_dport;

  always_comb begin
    hd_tuple = '0;
    for (int i = 0; i < 12; i++) hd_tuple[95-8*i -: 8] = hdr_cur[26+i];
    proto    = hdr_cur[23];
    ipv4     = !short_frame && {hdr_cur[12], hdr_cur[13]} == 16'h0800 && hdr_cur[14] == 8'h45;
    frag     = ({hdr_cur[20], hdr_cur[21]} & 16'h3FFF) != 16'h0000;
    hd_type  = 4'b0000;
    hd_len   = 4'd0;
    hd_dip   = '0;
    hd_dport = '0;
    if (ipv4) begin
      hd_dip  = {hdr_cur[30], hdr_cur[31], hdr_cur[32], hdr_cur[33]};
      hd_type = 4'b0001;
      hd_len  = 4'd8;
      if (!frag && (proto == 8'd6 || proto == 8'd17)) begin
        hd_type  = (proto == 8'd6) ? 4'b0011 : 4'b0101;
        hd_len   = 4'd12;
        hd_dport = {hdr_cur[36], hdr_cur[37]};
      end
    end
  end

  logic [QUEUE_BITS-1:0] table_q [TBL_DEPTH];

  // NOTE: this table must reset to a known spread, so unlike a plain RAM it is
  // built from resettable flops rather than left uninitialised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) table_q[i] <= QUEUE_BITS'(i);
    end else if (tbl_wr_en) begin
      table_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  state_e                state_q;
  logic [95:0]           tuple_q;
  logic [319:0]          key_q;
  logic [3:0]            cnt_q, type_l_q;
  logic [31:0]           acc_q, dip_l_q, hash_q, dip_q;
  logic [15:0]           dport_l_q, dport_q, drop_q;
  logic [3:0]            type_q;
  logic [QUEUE_BITS-1:0] queue_q;
  logic                  valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tuple_q   <= '0;
      key_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      type_l_q  <= '0;
      dip_l_q   <= '0;
      dport_l_q <= '0;
      hash_q    <= '0;
      type_q    <= '0;
      queue_q   <= '0;
      dip_q     <= '0;
      dport_q   <= '0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (hdr_done && state_q != ST_IDLE && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      case (state_q)
        ST_IDLE: if (hdr_done) begin
          tuple_q   <= hd_tuple;
          key_q     <= hash_key;
          cnt_q     <= hd_len;
          acc_q     <= '0;
          type_l_q  <= hd_type;
          dip_l_q   <= hd_dip;
          dport_l_q <= hd_dport;
          state_q   <= (hd_len != 4'd0) ? ST_HASH : ST_LOAD;
        end
        ST_HASH: begin
          // Tuple and key shift together so the current byte and its key window sit at the top.
          acc_q   <= hash_byte(acc_q, tuple_q[95:88], key_q);
          tuple_q <= tuple_q << 8;
          key_q   <= key_q << 8;
          cnt_q   <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          hash_q  <= acc_q;
          queue_q <= table_q[acc_q[INDIR_BITS-1:0]];
          type_q  <= type_l_q;
          dip_q   <= dip_l_q;
          dport_q <= dport_l_q;
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: if (m_axis_hash_ready) begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_hash       = hash_q;
  assign m_axis_hash_type  = type_q;
  assign m_axis_hash_queue = queue_q;
  assign m_axis_dest_ip    = dip_q;
  assign m_axis_dest_port  = dport_q;
  assign m_axis_hash_valid = valid_q;
  assign drop_count        = drop_q;
endmodule

// File: tb/tb_rx_hash_steer.sv
// Scoreboard bench for rx_hash_steer: a 256-bit and a 64-bit instance driven with
// directed frames against the published RSS verification vectors.
module tb_rx_hash_steer;
  localparam logic [319:0] KEY =
    320'h6d5a56da255b0ec24167253d43a38fb0d0ca2bcbae7b30b477cb2da38030f20c6a42b73bbeac01fa;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [255:0] a_tdata;
  logic [31:0]  a_tkeep;
  logic         a_tvalid, a_tlast, a_ready, a_valid;
  logic [31:0]  a_hash, a_dip;
  logic [3:0]   a_type, a_queue;
  logic [15:0]  a_dport, a_drop;

  logic [63:0]  b_tdata;
  logic [7:0]   b_tkeep;
  logic         b_tvalid, b_tlast, b_valid;
  logic         b_ready = 1'b1;
  logic         b_wr_en = 1'b0;
  logic [6:0]   b_wr_addr = '0;
  logic [3:0]   b_wr_data = '0;
  logic [31:0]  b_hash, b_dip;
  logic [3:0]   b_type, b_queue;
  logic [15:0]  b_dport, b_drop;

  logic         tbl_wr_en;
  logic [6:0]   tbl_wr_addr;
  logic [3:0]   tbl_wr_data;

  rx_hash_steer #(.DATA_WIDTH(256)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
    .s_axis_tlast(a_tlast), .hash_key(KEY),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .m_axis_hash(a_hash), .m_axis_hash_type(a_type), .m_axis_hash_queue(a_queue),
    .m_axis_dest_ip(a_dip), .m_axis_dest_port(a_dport), .m_axis_hash_valid(a_valid),
    .m_axis_hash_ready(a_ready), .drop_count(a_drop));

  rx_hash_steer #(.DATA_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(b_tlast), .hash_key(KEY),
    .tbl_wr_en(b_wr_en), .tbl_wr_addr(b_wr_addr), .tbl_wr_data(b_wr_data),
    .m_axis_hash(b_hash), .m_axis_hash_type(b_type), .m_axis_hash_queue(b_queue),
    .m_axis_dest_ip(b_dip), .m_axis_dest_port(b_dport), .m_axis_hash_valid(b_valid),
    .m_axis_hash_ready(b_ready), .drop_count(b_drop));

  typedef struct {
    logic [31:0] hash;
    logic [3:0]  typ;
    logic [3:0]  qn;
    logic [31:0] dip;
    bit          chk_dip;
    logic [15:0] dport;
    int          rise;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_hdr = 0;
  logic [7:0] fr [64];
  int   fr_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [3:0] t, input logic [3:0] q,
                              input bit cd, input logic [15:0] p);
    exp_t e;
    e.hash = h; e.typ = t; e.qn = q; e.dip = 32'hA18E6450; e.chk_dip = cd; e.dport = p;
    e.rise = 0;
    return e;
  endfunction

  function automatic int tuple_n(input logic [3:0] t);
    return (t == 4'b0011 || t == 4'b0101) ? 12 : (t == 4'b0001) ? 8 : 0;
  endfunction

  // Flow 66.9.149.187:2794 -> 161.142.100.80:1766 in a 64-byte frame.
  task automatic build(input logic [15:0] etype, input logic [15:0] flags, input logic [7:0] proto);
    logic [7:0] tup [12];
    tup = '{8'h42, 8'h09, 8'h95, 8'hBB, 8'hA1, 8'h8E, 8'h64, 8'h50, 8'h0A, 8'hEA, 8'h06, 8'hE6};
    for (int i = 0; i < 64; i++) fr[i] = 8'(i);
    fr[12] = etype[15:8]; fr[13] = etype[7:0]; fr[14] = 8'h45;
    fr[20] = flags[15:8]; fr[21] = flags[7:0]; fr[23] = proto;
    for (int i = 0; i < 12; i++) fr[26+i] = tup[i];
    fr_len = 64;
  endtask

  task automatic drive_a(input exp_t e, input bit push);
    int nb, hb;
    nb = (fr_len + 31) / 32;
    hb = (nb < 2) ? nb - 1 : 1;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      for (int j = 0; j < 32; j++) begin
        int idx;
        idx = b*32 + j;
        a_tdata[j*8 +: 8] = (idx < fr_len) ? fr[idx] : 8'h00;
        a_tkeep[j] = (idx < fr_len);
      end
      a_tvalid = 1'b1;
      a_tlast  = (b == nb - 1);
      if (b == hb) begin
        last_hdr = cyc + 1;
        e.rise   = cyc + 1 + tuple_n(e.typ) + 1;
        if (push) qa.push_back(e);
      end
    end
    @(negedge clk);
    a_tvalid = 1'b0;
    a_tlast  = 1'b0;
  endtask

  task automatic drive_b(input exp_t e);
    int nb, hb;
    nb = (fr_len + 7) / 8;
    hb = (nb < 5) ? nb - 1 : 4;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = b*8 + j;
        b_tdata[j*8 +: 8] = (idx < fr_len) ? fr[idx] : 8'h00;
        b_tkeep[j] = (idx < fr_len);
      end
      b_tvalid = 1'b1;
      b_tlast  = (b == nb - 1);
      if (b == hb) begin
        e.rise = cyc + 1 + tuple_n(e.typ) + 1;
        qb.push_back(e);
      end
    end
    @(negedge clk);
    b_tvalid = 1'b0;
    b_tlast  = 1'b0;
  endtask

  task automatic cmp(input string p, input exp_t e, input logic [31:0] h, input logic [3:0] t,
                     input logic [3:0] q, input logic [31:0] d, input logic [15:0] pt, input int r);
    check({p, ".hash"}, h, e.hash);
    check({p, ".type"}, 32'(t), 32'(e.typ));
    check({p, ".queue"}, 32'(q), 32'(e.qn));
    check({p, ".dest_port"}, 32'(pt), 32'(e.dport));
    if (e.chk_dip) check({p, ".dest_ip"}, d, e.dip);
    check({p, ".latency_cycle"}, 32'(r), 32'(e.rise));
  endtask

  logic a_vprev = 1'b0, b_vprev = 1'b0;
  int   a_rise = 0, b_rise = 0;

  always @(negedge clk) begin
    int r;
    exp_t e;
    if (!rst) begin
      a_vprev <= 1'b0;
    end else begin
      a_vprev <= a_valid;
      if (a_valid && !a_vprev) a_rise <= cyc;
      if (a_valid && a_ready) begin
        r = a_vprev ? a_rise : cyc;
        if (qa.size() == 0) check("a.unexpected_result", 32'(a_valid), 32'd0);
        else begin
          e = qa.pop_front();
          cmp("a", e, a_hash, a_type, a_queue, a_dip, a_dport, r);
        end
      end
    end
  end

  always @(negedge clk) begin
    int r;
    exp_t e;
    if (!rst) begin
      b_vprev <= 1'b0;
    end else begin
      b_vprev <= b_valid;
      if (b_valid && !b_vprev) b_rise <= cyc;
      if (b_valid && b_ready) begin
        r = b_vprev ? b_rise : cyc;
        if (qb.size() == 0) check("b.unexpected_result", 32'(b_valid), 32'd0);
        else begin
          e = qb.pop_front();
          cmp("b", e, b_hash, b_type, b_queue, b_dip, b_dport, r);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    check("pending_results_after_timeout", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  task automatic check_a_zero(input string p);
    check({p, ".valid"}, 32'(a_valid), 32'd0);
    check({p, ".hash"}, a_hash, 32'd0);
    check({p, ".type"}, 32'(a_type), 32'd0);
    check({p, ".queue"}, 32'(a_queue), 32'd0);
    check({p, ".dest_ip"}, a_dip, 32'd0);
    check({p, ".dest_port"}, 32'(a_dport), 32'd0);
    check({p, ".drop_count"}, 32'(a_drop), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    a_tdata = '0; a_tkeep = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_ready = 1'b1;
    b_tdata = '0; b_tkeep = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset.b_valid", 32'(b_valid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // TCP flow on both widths; the 64-bit instance sees byte 37 on beat 4.
    build(16'h0800, 16'h0000, 8'd6);
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd8, 1'b1, 16'h06E6), 1'b1);
    drive_b(mk(32'h51ccc178, 4'b0011, 4'd8, 1'b1, 16'h06E6));
    wait_idle();

    build(16'h0800, 16'h2000, 8'd6);
    drive_a(mk(32'h323e8fc2, 4'b0001, 4'd2, 1'b1, 16'h0000), 1'b1);
    wait_idle();

    build(16'h0800, 16'h0000, 8'd17);
    drive_a(mk(32'h51ccc178, 4'b0101, 4'd8, 1'b1, 16'h06E6), 1'b1);
    wait_idle();

    build(16'h0800, 16'h0000, 8'd1);
    drive_a(mk(32'h323e8fc2, 4'b0001, 4'd2, 1'b1, 16'h0000), 1'b1);
    wait_idle();

    build(16'h86DD, 16'h0000, 8'd6);
    drive_a(mk(32'h0, 4'b0000, 4'd0, 1'b0, 16'h0000), 1'b1);
    wait_idle();

    build(16'h0800, 16'h0000, 8'd6);
    fr_len = 30;
    drive_a(mk(32'h0, 4'b0000, 4'd0, 1'b0, 16'h0000), 1'b1);
    wait_idle();

    // Three back-to-back frames with ready low: first is held, two are dropped.
    @(posedge clk); #1 a_ready = 1'b0;
    build(16'h0800, 16'h0000, 8'd6);
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd8, 1'b1, 16'h06E6), 1'b1);
    drive_a(mk(32'h0, 4'b0000, 4'd0, 1'b0, 16'h0000), 1'b0);
    drive_a(mk(32'h0, 4'b0000, 4'd0, 1'b0, 16'h0000), 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("held.valid", 32'(a_valid), 32'd1);
      check("held.hash", a_hash, 32'h51ccc178);
      check("held.dest_port", 32'(a_dport), 32'h06E6);
      @(negedge clk);
    end
    check("held.drop_count", 32'(a_drop), 32'd2);
    @(posedge clk); #1 a_ready = 1'b1;
    wait_idle();
    repeat (30) @(negedge clk);
    check("after_drain.valid", 32'(a_valid), 32'd0);

    // Table write, then a write that collides with the lookup edge.
    @(negedge clk);
    tbl_wr_en = 1'b1; tbl_wr_addr = 7'h78; tbl_wr_data = 4'd9;
    @(negedge clk);
    tbl_wr_en = 1'b0;
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd9, 1'b1, 16'h06E6), 1'b1);
    wait_idle();
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd9, 1'b1, 16'h06E6), 1'b1);
    while (cyc < last_hdr + 12) @(negedge clk);
    tbl_wr_en = 1'b1; tbl_wr_addr = 7'h78; tbl_wr_data = 4'd5;
    @(negedge clk);
    tbl_wr_en = 1'b0;
    wait_idle();
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd5, 1'b1, 16'h06E6), 1'b1);
    wait_idle();

    // Reset in the middle of hashing aborts the result and restores the table.
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd5, 1'b1, 16'h06E6), 1'b1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    qa.delete();
    #1 check_a_zero("mid_hash_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset.valid", 32'(a_valid), 32'd0);
    drive_a(mk(32'h51ccc178, 4'b0011, 4'd8, 1'b1, 16'h06E6), 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
